mul_seq_ctrl: RTL and testbench

//  Sequencing controller for the iterative M-extension multiplier in the single-cycle core.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_seq_ctrl_core.sv | 43 ++++
 rtl/mul_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and encodings for the iterative M-extension multiplier.
// Imported by the sequencing controller.
package mul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIXUP,
        DONE
    } mul_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/mul_seq_ctrl_core.sv
// Unsigned shift-add multiplier datapath.
// Retires BITS_PER_CYC multiplier bits per step into a 2*XLEN accumulator.
module mul_iter_core #(
    parameter int XLEN         = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [XLEN-1:0]   mcand,
    input  logic [XLEN-1:0]   mplier,
    output logic [2*XLEN-1:0] product
);

    localparam int B = BITS_PER_CYC;

    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN+B-1:0] partial;
    logic [XLEN+B-1:0] sum;

    // Low half starts as the multiplier and is consumed from the bottom
    always_comb begin
        partial = {{B{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc_q[B-1:0]};
        sum     = {{B{1'b0}}, acc_q[2*XLEN-1:XLEN]} + partial;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (load) begin
            mcand_q <= mcand;
            acc_q   <= {{XLEN{1'b0}}, mplier};
        end else if (step) begin
            acc_q   <= {sum, acc_q[XLEN-1:B]};
        end
    end

    assign product = acc_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for the iterative MUL/MULH/MULHSU/MULHU unit.
// Stalls the core, runs the shift-add core, fixes sign, emits one write-back beat.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_req,
    input  logic [2:0]      mul_funct3,
    input  logic [XLEN-1:0] mul_rs1,
    input  logic [XLEN-1:0] mul_rs2,
    output logic            mul_stall,
    output logic            mul_wb_en,
    output logic [XLEN-1:0] mul_result,
    output logic            mul_busy,
    output logic            mul_illegal,
    output logic [XLEN-1:0] mul_debug
);

    localparam int RUN_CYC = XLEN / BITS_PER_CYC;
    localparam int CW      = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(RUN_CYC - 1);

    mul_state_t        state_q, state_d;
    logic [1:0]        f3_q;
    logic [XLEN-1:0]   rs1_q, rs2_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    logic              legal_req;
    logic              sgn_a, sgn_b;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] fixed;
    logic [XLEN-1:0]   half;

    assign legal_req = mul_req & ~mul_funct3[2];

    always_comb begin
        sgn_a = ({1'b0, f3_q} == F3_MULH) || ({1'b0, f3_q} == F3_MULHSU);
        sgn_b = ({1'b0, f3_q} == F3_MULH);
        neg_a = sgn_a & rs1_q[XLEN-1];
        neg_b = sgn_b & rs2_q[XLEN-1];
        mag_a = neg_a ? -rs1_q : rs1_q;
        mag_b = neg_b ? -rs2_q : rs2_q;
    end

    mul_iter_core #(
        .XLEN         (XLEN),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (state_q == LOAD),
        .step    (state_q == RUN),
        .mcand   (mag_a),
        .mplier  (mag_b),
        .product (prod)
    );

    always_comb begin
        fixed = neg_q ? -prod : prod;
        half  = ({1'b0, f3_q} == F3_MUL) ? fixed[XLEN-1:0]
                                         : fixed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            f3_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && legal_req) begin
                f3_q  <= mul_funct3[1:0];
                rs1_q <= mul_rs1;
                rs2_q <= mul_rs2;
            end
            if (state_q == LOAD) begin
                neg_q <= neg_a ^ neg_b;
                cnt_q <= CNT_INIT;
            end
            if (state_q == RUN && cnt_q != '0)
                cnt_q <= cnt_q - CW'(1);
            // Result is registered so it is stable through DONE and after
            if (state_q == FIXUP)
                result_q <= half;
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_stall   = 1'b0;
        mul_wb_en   = 1'b0;
        mul_illegal = 1'b0;
        unique case (state_q)
            IDLE: begin
                mul_illegal = rst & mul_req & mul_funct3[2];
                if (legal_req && rst) begin
                    mul_stall = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                mul_stall = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                mul_stall = 1'b1;
                if (cnt_q == '0)
                    state_d = FIXUP;
            end
            FIXUP: begin
                mul_stall = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                mul_wb_en = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mul_busy   = (state_q != IDLE);
    assign mul_result = result_q;
    assign mul_debug  = prod[XLEN-1:0];

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl.
// Models the core PC as a +4 counter gated by mul_stall.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_req;
    logic [2:0]  mul_funct3;
    logic [31:0] mul_rs1;
    logic [31:0] mul_rs2;
    logic        mul_stall;
    logic        mul_wb_en;
    logic [31:0] mul_result;
    logic        mul_busy;
    logic        mul_illegal;
    logic [31:0] mul_debug;

    int          tests = 0;
    int          fails = 0;
    int          ncyc  = 0;
    logic [31:0] pc;

    mul_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mul_req     (mul_req),
        .mul_funct3  (mul_funct3),
        .mul_rs1     (mul_rs1),
        .mul_rs2     (mul_rs2),
        .mul_stall   (mul_stall),
        .mul_wb_en   (mul_wb_en),
        .mul_result  (mul_result),
        .mul_busy    (mul_busy),
        .mul_illegal (mul_illegal),
        .mul_debug   (mul_debug)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst)
            pc <= 32'h0;
        else if (!mul_stall)
            pc <= pc + 32'd4;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op and leaves mul_req high just after the DONE edge
    task automatic run_mul(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, output int wb_at);
        int          cyc;
        int          gaps;
        logic [31:0] pc0;
        mul_req    = 1'b1;
        mul_funct3 = f3;
        mul_rs1    = a;
        mul_rs2    = b;
        #1;
        check({tag, ":stall0"}, 32'(mul_stall), 32'd1);
        pc0  = pc;
        cyc  = 0;
        gaps = 0;
        while (!mul_wb_en && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!mul_wb_en && !mul_stall)
                gaps++;
        end
        wb_at = ncyc;
        check({tag, ":lat"}, 32'(cyc), 32'd35);
        check({tag, ":gaps"}, 32'(gaps), 32'd0);
        check({tag, ":res"}, mul_result, exp_res);
        check({tag, ":done_stall"}, 32'(mul_stall), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ":pc"}, pc, pc0 + 32'd4);
        check({tag, ":wb_off"}, 32'(mul_wb_en), 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int wbs;

        rst        = 1'b0;
        mul_req    = 1'b0;
        mul_funct3 = 3'b000;
        mul_rs1    = 32'h0;
        mul_rs2    = 32'h0;
        #1;
        check("rst:stall", 32'(mul_stall), 32'd0);
        check("rst:wb", 32'(mul_wb_en), 32'd0);
        check("rst:res", mul_result, 32'h0);
        check("rst:busy", 32'(mul_busy), 32'd0);
        check("rst:ill", 32'(mul_illegal), 32'd0);
        check("rst:dbg", mul_debug, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_mul("mul7x6", 3'b000, 32'd7, 32'd6, 32'h0000002A, t1);
        mul_req = 1'b0;
        run_mul("mulh_ff", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h00000000, t1);
        mul_req = 1'b0;
        run_mul("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, t1);
        mul_req = 1'b0;
        run_mul("mulhsu_ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFF, t1);
        mul_req = 1'b0;
        run_mul("mul_min", 3'b000, 32'h80000000, 32'hFFFFFFFF,
                32'h80000000, t1);
        mul_req = 1'b0;
        run_mul("mulh_min", 3'b001, 32'h80000000, 32'hFFFFFFFF,
                32'h00000000, t1);
        mul_req = 1'b0;
        @(posedge clk);
        #1;

        t0 = ncyc;
        run_mul("b2b_a", 3'b000, 32'd3, 32'd5, 32'h0000000F, t1);
        run_mul("b2b_b", 3'b011, 32'h00010000, 32'h00010000,
                32'h00000001, wbs);
        mul_req = 1'b0;
        check("b2b:first_at", 32'(t1 - t0), 32'd35);
        check("b2b:second_at", 32'(wbs - t0), 32'd71);

        mul_req    = 1'b1;
        mul_funct3 = 3'b000;
        mul_rs1    = 32'd9;
        mul_rs2    = 32'd9;
        #1;
        repeat (11) @(posedge clk);
        #1;
        check("rrun:busy", 32'(mul_busy), 32'd1);
        mul_req = 1'b0;
        rst     = 1'b0;
        #1;
        check("rrun:stall", 32'(mul_stall), 32'd0);
        check("rrun:busy0", 32'(mul_busy), 32'd0);
        check("rrun:wb", 32'(mul_wb_en), 32'd0);
        check("rrun:res", mul_result, 32'h0);
        check("rrun:dbg", mul_debug, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wbs = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mul_wb_en)
                wbs++;
        end
        check("rrun:no_wb", 32'(wbs), 32'd0);
        run_mul("mul2x2", 3'b000, 32'd2, 32'd2, 32'h00000004, t1);
        mul_req = 1'b0;
        @(posedge clk);
        #1;

        mul_req    = 1'b1;
        mul_funct3 = 3'b100;
        mul_rs1    = 32'd7;
        mul_rs2    = 32'd6;
        #1;
        check("ill:pulse", 32'(mul_illegal), 32'd1);
        check("ill:stall", 32'(mul_stall), 32'd0);
        @(posedge clk);
        #1;
        mul_req = 1'b0;
        #1;
        check("ill:busy", 32'(mul_busy), 32'd0);
        check("ill:off", 32'(mul_illegal), 32'd0);
        check("ill:stall2", 32'(mul_stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
